// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: dmem-priority FSM sharing one main memory port.
// Define IFETCH_STARVE_GUARD_EN to bound consecutive dmem wins over a pending fetch.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  input  logic        imem_flush,
  output logic        imem_gnt,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic        dmem_gnt,
  output logic        dmem_rvalid,
  output logic [31:0] dmem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        flush_q;

  logic idle;
  logic busy;
  logic starve_hit;
  logic i_win;
  logic d_win;

  assign idle = (state == IDLE);
  assign busy = (state == IBUSY) || (state == DBUSY);

`ifdef IFETCH_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign starve_hit = (starve_cnt == 4'(STARVE_LIMIT));

  // Counts dmem wins while a fetch waits; any fetch grant resets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (idle) begin
      if (!imem_req || i_win)
        starve_cnt <= 4'd0;
      else if (d_win && starve_cnt != 4'hf)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign d_win = idle && dmem_req && !(imem_req && starve_hit);
  assign i_win = idle && imem_req && !d_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          flush_q <= 1'b0;
          if (d_win) begin
            state   <= DBUSY;
            addr_q  <= dmem_addr;
            we_q    <= dmem_we;
            wdata_q <= dmem_we ? dmem_wdata : 32'd0;
          end else if (i_win) begin
            state   <= IBUSY;
            addr_q  <= imem_addr;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
          end
        end
        IBUSY: begin
          // A flush seen on any wait cycle kills the eventual response.
          if (mem_ready) begin
            state   <= IDLE;
            flush_q <= 1'b0;
          end else begin
            flush_q <= flush_q | imem_flush;
          end
        end
        DBUSY: begin
          if (mem_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    imem_gnt    = 1'b0;
    dmem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    dmem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    dmem_rdata  = 32'd0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    mem_re      = 1'b0;
    mem_wr      = 1'b0;
    if (!rst) begin
      imem_gnt = i_win;
      dmem_gnt = d_win;
      if (busy) begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_re    = ~we_q;
        mem_wr    = we_q;
      end
      if (state == IBUSY && mem_ready && !flush_q && !imem_flush) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_rdata;
      end
      if (state == DBUSY && mem_ready) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = we_q ? 32'd0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, store waits,
// flush, async reset and starvation behaviour.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_flush;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_flush(imem_flush), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .mem_addr(mem_addr),
    .mem_re(mem_re), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_req = 1'b1; imem_addr = 32'h0; imem_flush = 1'b0;
    dmem_req = 1'b1; dmem_we = 1'b0;
    dmem_addr = 32'h0; dmem_wdata = 32'h0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;

    // Reset: all outputs low even with requests present
    @(negedge clk);
    chk("rst_igt", 32'(imem_gnt), 32'd0);
    chk("rst_dgt", 32'(dmem_gnt), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_drv", 32'(dmem_rvalid), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    cyc();
    rst = 1'b0;
    imem_req = 1'b0; dmem_req = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Single fetch
    imem_req = 1'b1; imem_addr = 32'h100;
    @(negedge clk);
    chk("f_gnt", 32'(imem_gnt), 32'd1);
    chk("f_dgnt", 32'(dmem_gnt), 32'd0);
    chk("f_idle_re", 32'(mem_re), 32'd0);
    cyc();
    imem_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    @(negedge clk);
    chk("f_re", 32'(mem_re), 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_rv", 32'(imem_rvalid), 32'd1);
    chk("f_rd", imem_rdata, 32'h0050_0093);
    chk("f_gnt0", 32'(imem_gnt), 32'd0);
    cyc();
    mem_ready = 1'b0; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("f_re0", 32'(mem_re), 32'd0);
    chk("f_addr0", mem_addr, 32'd0);
    chk("f_rv0", 32'(imem_rvalid), 32'd0);
    chk("f_rd0", imem_rdata, 32'd0);
    cyc();

    // Contention: load wins, fetch follows
    imem_req = 1'b1; imem_addr = 32'h200;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h2000;
    @(negedge clk);
    chk("c_dgnt", 32'(dmem_gnt), 32'd1);
    chk("c_ignt", 32'(imem_gnt), 32'd0);
    cyc();
    dmem_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("c_addr", mem_addr, 32'h2000);
    chk("c_re", 32'(mem_re), 32'd1);
    chk("c_drv", 32'(dmem_rvalid), 32'd1);
    chk("c_drd", dmem_rdata, 32'hCAFE_F00D);
    chk("c_igt_busy", 32'(imem_gnt), 32'd0);
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("c_igt", 32'(imem_gnt), 32'd1);
    cyc();
    imem_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
    @(negedge clk);
    chk("c_iaddr", mem_addr, 32'h200);
    chk("c_irv", 32'(imem_rvalid), 32'd1);
    cyc();
    mem_ready = 1'b0;

    // Store with three wait states
    dmem_req = 1'b1; dmem_we = 1'b1;
    dmem_addr = 32'h40; dmem_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("s_gnt", 32'(dmem_gnt), 32'd1);
    cyc();
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s_wr", 32'(mem_wr), 32'd1);
      chk("s_re", 32'(mem_re), 32'd0);
      chk("s_addr", mem_addr, 32'h40);
      chk("s_wd", mem_wdata, 32'hDEAD_BEEF);
      chk("s_rv_wait", 32'(dmem_rvalid), 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("s_wr4", 32'(mem_wr), 32'd1);
    chk("s_wd4", mem_wdata, 32'hDEAD_BEEF);
    chk("s_rv", 32'(dmem_rvalid), 32'd1);
    chk("s_rd", dmem_rdata, 32'd0);
    cyc();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("s_wr0", 32'(mem_wr), 32'd0);
    chk("s_wd0", mem_wdata, 32'd0);
    cyc();

    // Flush on second wait cycle of a three-cycle fetch
    imem_req = 1'b1; imem_addr = 32'h300;
    @(negedge clk);
    chk("fl_gnt", 32'(imem_gnt), 32'd1);
    cyc();
    imem_req = 1'b0;
    @(negedge clk);
    chk("fl_re1", 32'(mem_re), 32'd1);
    cyc();
    imem_flush = 1'b1;
    @(negedge clk);
    chk("fl_re2", 32'(mem_re), 32'd1);
    chk("fl_rv2", 32'(imem_rvalid), 32'd0);
    cyc();
    imem_flush = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("fl_re3", 32'(mem_re), 32'd1);
    chk("fl_rv3", 32'(imem_rvalid), 32'd0);
    chk("fl_rd3", imem_rdata, 32'd0);
    cyc();
    mem_ready = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h304; imem_flush = 1'b1;
    @(negedge clk);
    chk("fl_idle_re", 32'(mem_re), 32'd0);
    chk("fl_idle_gnt", 32'(imem_gnt), 32'd1);
    cyc();
    imem_req = 1'b0; imem_flush = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h99;
    @(negedge clk);
    chk("fl_next_addr", mem_addr, 32'h304);
    chk("fl_next_rv", 32'(imem_rvalid), 32'd1);
    chk("fl_next_rd", imem_rdata, 32'h99);
    cyc();
    mem_ready = 1'b0;

    // Async reset mid-load
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h3000;
    @(negedge clk);
    chk("ar_gnt", 32'(dmem_gnt), 32'd1);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'hABCD_0123;
    @(negedge clk);
    chk("ar_re", 32'(mem_re), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_re0", 32'(mem_re), 32'd0);
    chk("ar_wr0", 32'(mem_wr), 32'd0);
    chk("ar_addr0", mem_addr, 32'd0);
    chk("ar_dgnt0", 32'(dmem_gnt), 32'd0);
    chk("ar_drv0", 32'(dmem_rvalid), 32'd0);
    chk("ar_drd0", dmem_rdata, 32'd0);
    cyc();
    rst = 1'b0; dmem_req = 1'b0;
    @(negedge clk);
    chk("ar_stale", 32'(dmem_rvalid), 32'd0);
    chk("ar_idle_re", 32'(mem_re), 32'd0);
    cyc();

    // Both requesters held high: six arbitration rounds
    imem_req = 1'b1; imem_addr = 32'h500;
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h4000;
    mem_ready = 1'b1; mem_rdata = 32'h1;
    for (int k = 0; k < 6; k++) begin
      logic exp_i;
`ifdef IFETCH_STARVE_GUARD_EN
      exp_i = (k == 4);
`else
      exp_i = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("sv_igt%0d", k), 32'(imem_gnt), 32'(exp_i));
      chk($sformatf("sv_dgt%0d", k), 32'(dmem_gnt), 32'(!exp_i));
      cyc();
      @(negedge clk);
      chk($sformatf("sv_addr%0d", k), mem_addr,
          exp_i ? 32'h500 : 32'h4000);
      cyc();
    end
    imem_req = 1'b0; dmem_req = 1'b0; mem_ready = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
